// File: rtl/button_gesture.sv
// Classifies debounced button interactions into short, long and double presses,
// emitting one registered single-cycle pulse per recognised gesture.
module button_gesture #(
  parameter bit C_ACTIVE   = 1'b1,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int LONG_MS    = 1000,
  parameter int DOUBLE_MS  = 300,
  parameter int RELEASE_MS = 10
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PRESS,
  input  logic PIN,
  output logic SHORT_PRESS,
  output logic LONG_PRESS,
  output logic DOUBLE_PRESS,
  output logic BUSY
);

  localparam int TICKS_MS = CLK_FREQ / 1000;
  localparam int L        = TICKS_MS * LONG_MS;
  localparam int D        = TICKS_MS * DOUBLE_MS;
  localparam int R        = TICKS_MS * RELEASE_MS;
  localparam int T_MAX    = (L > D) ? L : D;
  localparam int TW       = $clog2(T_MAX + 1);
  localparam int RW       = $clog2(R + 1);

  localparam logic [TW-1:0] L_LOAD = TW'(L);
  localparam logic [TW-1:0] D_LOAD = TW'(D);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [RW-1:0] R_SAT  = RW'(R);
  localparam logic [RW-1:0] R_LAST = RW'(R - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, WAIT2, HELD} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   rel_cnt;
  logic            pin_meta;
  logic            pin_sync;

  // The raw pin is asynchronous; it only feeds release qualification.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pin_meta <= ~C_ACTIVE;
      pin_sync <= ~C_ACTIVE;
    end else begin
      pin_meta <= PIN;
      pin_sync <= pin_meta;
    end
  end

  logic          act;
  logic          released;
  logic          timer_hit;
  logic [RW-1:0] rel_next;
  logic [TW-1:0] timer_dec;

  assign act       = (pin_sync == C_ACTIVE);
  assign rel_next  = act ? '0 : ((rel_cnt == R_SAT) ? R_SAT : rel_cnt + 1'b1);
  // Release is the edge on which the inactive run reaches R, not any later one.
  assign released  = !act && (rel_cnt == R_LAST);
  assign timer_hit = (timer == T_ONE);
  assign timer_dec = (timer == '0) ? '0 : timer - 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      timer        <= '0;
      rel_cnt      <= '0;
      SHORT_PRESS  <= 1'b0;
      LONG_PRESS   <= 1'b0;
      DOUBLE_PRESS <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; a later non-blocking assignment
      // in the case below overrides this default for the one cycle it fires.
      SHORT_PRESS  <= 1'b0;
      LONG_PRESS   <= 1'b0;
      DOUBLE_PRESS <= 1'b0;
      rel_cnt      <= rel_next;

      case (state)
        IDLE: begin
          timer <= '0;
          if (PRESS) begin
            timer   <= L_LOAD;
            rel_cnt <= '0;
            state   <= PRESSED;
            BUSY    <= 1'b1;
          end
        end

        PRESSED: begin
          timer <= timer_dec;
          if (released) begin
            timer <= D_LOAD;
            state <= WAIT2;
          end else if (timer_hit) begin
            LONG_PRESS <= 1'b1;
            state      <= HELD;
          end
        end

        WAIT2: begin
          timer <= timer_dec;
          if (PRESS) begin
            DOUBLE_PRESS <= 1'b1;
            rel_cnt      <= '0;
            timer        <= '0;
            state        <= HELD;
          end else if (timer_hit) begin
            SHORT_PRESS <= 1'b1;
            state       <= IDLE;
            BUSY        <= 1'b0;
          end
        end

        HELD: begin
          timer <= '0;
          if (released) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_gesture.md
Name: button_gesture

Overview:
- Sits directly downstream of the debounced edge detector (the `button` block).
- Consumes its one-cycle PRESS pulse and the raw pin, and classifies each user interaction as a short press, long press or double press.
- Emits one single-cycle pulse per classified gesture to control logic such as mode switches and menu stepping.

Parameters:
C_ACTIVE, 1, active pin level (1 = active-high pin, 0 = active-low pin)
CLK_FREQ, 100000000, CLK frequency in Hz; must be a multiple of 1000
LONG_MS, 1000, hold time that qualifies a long press
DOUBLE_MS, 300, window after a release in which a second press makes a double press
RELEASE_MS, 10, time the pin must stay continuously inactive before a release is accepted

Ports:
CLK  input  1  system clock; all logic on posedge
RESET  input  1  asynchronous, active-high reset
PRESS  input  1  one-cycle debounced active-edge pulse from the upstream edge detector
PIN  input  1  raw button pin (same pin that feeds the upstream edge detector), asynchronous
SHORT_PRESS  output  1  one-cycle pulse: short press classified
LONG_PRESS  output  1  one-cycle pulse: long press classified
DOUBLE_PRESS  output  1  one-cycle pulse: double press classified
BUSY  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Derived constants:
  - L = CLK_FREQ/1000*LONG_MS
  - D = CLK_FREQ/1000*DOUBLE_MS
  - R = CLK_FREQ/1000*RELEASE_MS
  - One shared down-timer, width $clog2(max(L,D)+1); release counter width $clog2(R+1).
- PIN synchronisation:
  - 2-FF synchroniser, reset to the inactive level (~C_ACTIVE).
  - act = (synced level == C_ACTIVE).
- Release counter:
  - Cleared on any cycle act=1; otherwise increments, saturating at R.
  - "Release confirmed" = the edge at which the counter reaches R.
  - Raw PIN going inactive just before edge E0 therefore gives release confirmed at edge E0+R+1.
- Reset (async, RESET=1):
  - State IDLE; all outputs 0; timer 0; counters 0; synchroniser inactive.
  - Asserting RESET mid-gesture aborts it with no pulse emitted.
- FSM states: IDLE, PRESSED, WAIT2, HELD.
  - IDLE: on PRESS, load timer=L, clear release counter, go to PRESSED.
  - PRESSED: timer decrements each cycle.
    - Release confirmed -> load timer=D, go to WAIT2.
    - Else if timer reaches 0 -> LONG_PRESS=1 for one cycle, go to HELD.
    - If both happen on the same edge, release wins (short path).
  - WAIT2: timer decrements each cycle.
    - PRESS -> DOUBLE_PRESS=1 for one cycle, clear release counter, go to HELD.
    - Else if timer reaches 0 -> SHORT_PRESS=1 for one cycle, go to IDLE.
    - If PRESS arrives on the expiry edge, PRESS wins (double).
  - HELD: ignore PRESS; release confirmed -> IDLE.
- PRESS is ignored in PRESSED and HELD, so upstream glitches cannot re-trigger.
- Timing:
  - PRESS sampled at edge P -> LONG_PRESS high for the cycle after edge P+L.
  - Release confirmed at edge C -> SHORT_PRESS high for the cycle after edge C+D.
- Outputs are registered; at most one of the three pulse outputs is high in any cycle.
- BUSY is registered from the state, and goes high the cycle after the PRESS that leaves IDLE.
- Timer never underflows; it holds at 0 in IDLE and HELD.

Test Plan:
All scenarios use CLK_FREQ=1000 (1 ms = 1 cycle), LONG_MS=20, DOUBLE_MS=10, RELEASE_MS=3, C_ACTIVE=1.
1. Reset: RESET held over 2 edges, then released with PIN=0 -> all outputs 0, BUSY=0; RESET pulsed 5 cycles into PRESSED -> no pulse for 40 cycles after, BUSY=0.
2. Short: PRESS at edge 10 with PIN high, PIN low before edge 15 -> release confirmed edge 19, SHORT_PRESS high exactly one cycle after edge 29, no other pulse, BUSY low after.
3. Long: PRESS at edge 10 with PIN held high for 50 cycles -> LONG_PRESS one cycle after edge 30, no SHORT on release, IDLE 4 cycles after PIN falls.
4. Double: short press as in 2, second PRESS at edge 25 -> DOUBLE_PRESS one cycle after edge 25, no SHORT_PRESS; after second release, returns to IDLE.
5. Bounce and tie-breaks:
   - PIN toggles low for 2 cycles during PRESSED -> release counter clears, no release confirmed.
   - Release confirmed on the same edge the L timer expires -> SHORT path taken, not LONG.
   - PRESS on the D-expiry edge -> DOUBLE_PRESS, not SHORT_PRESS.
6. Active-low: C_ACTIVE=0 with the inverted PIN of scenario 2 -> identical SHORT_PRESS timing.
